rate_tick_scheduler: RTL and testbench
======================================

// Module: rate_tick_scheduler
//
// PURPOSE
// - Multi-channel rate scheduler: converts per-channel requested rates (Hz) into periodic one-cycle
//   enable ticks, all derived from the single system clock inClock.
// - Owns one shared sequential divider that computes period = BASE_SPEED / speed for each channel.
// - Feeds sample, FFT-frame and display-refresh logic in the visualizer, so none of them need a
//   derived clock.
//
// PARAMETERS
// - BASE_SPEED  25000000  inClock frequency in Hz; the dividend for every period calculation.
// - NUM_CH      4         number of independent tick channels (1..16).
// - SPEED_W     20        width of a requested rate in Hz.
// - CNT_W       32        width of period registers, channel counters and the divider.
//
// PORTS
// - inClock    in   1                      system clock; all logic on posedge.
// - reset      in   1                      synchronous, active-high.
// - cfg_valid  in   1                      configuration request present.
// - cfg_ready  out  1                      scheduler can accept a request (high only in IDLE).
// - cfg_ch     in   $clog2(NUM_CH)         target channel index.
// - cfg_speed  in   SPEED_W                requested rate in Hz; 0 = disable channel.
// - busy       out  1                      a divide or commit is in progress.
// - ch_active  out  NUM_CH                 bit i = channel i has a nonzero period.
// - tick       out  NUM_CH                 one-cycle enable pulse per channel period.
//
// BEHAVIOUR
// - Reset (reset=1 at an edge):
//   - FSM goes to IDLE; all periods and channel counters go to 0.
//   - tick, ch_active and busy go to 0; cfg_ready is 1 on the following cycle.
//   - A reset during DIVIDE aborts the divide; nothing is committed.
// - Handshake: a request is accepted on any edge where cfg_valid && cfg_ready.
//   - cfg_ch and cfg_speed are captured at that edge.
//   - cfg_ready = (state==IDLE), driven combinationally from the state register.
//   - Requests with cfg_ch >= NUM_CH are accepted and then dropped: IDLE -> IDLE, no state change.
// - FSM:
//   - IDLE -> DIVIDE when a request with speed != 0 is accepted.
//   - IDLE -> COMMIT when a request with speed == 0 is accepted.
//   - DIVIDE runs exactly CNT_W cycles of restoring division, 1 quotient bit per cycle, then -> COMMIT.
//   - COMMIT lasts 1 cycle: it writes period[cfg_ch], clears cnt[cfg_ch] to 0, then -> IDLE.
//   - busy = (state != IDLE).
// - Latency:
//   - Accept at edge T gives period write at edge T+CNT_W+1 for speed!=0, and at edge T+1 for speed==0.
//   - The first tick of a reprogrammed channel is asserted during the cycle after edge
//     commit+period; the interval from the commit edge to the first tick equals the period.
// - Arithmetic:
//   - period = floor(BASE_SPEED / speed), zero-extended to CNT_W.
//   - If speed > BASE_SPEED, period clamps to 1: a tick on every cycle.
//   - Speed 0 gives period 0: channel disabled, tick stays 0, ch_active bit = 0.
// - Channel counters:
//   - When period != 0, cnt counts 0..period-1 and wraps.
//   - tick[i] is registered; it is 1 for the cycle after the edge where cnt == period-1.
//   - With period == 1, tick stays high continuously.
//   - All other channels keep counting undisturbed during a DIVIDE or COMMIT of channel i.
// - Reprogramming a channel that is already running: the old period stays in effect until the
//   COMMIT edge; the counter then restarts from 0 with no spurious tick at that edge.
//
// CONFIGURATION
// - Macro: RATE_SCHED_SQUARE_OUT_EN.
// - Defined:
//   - Adds output sq_out[NUM_CH], reset 0.
//   - sq_out[i] = 1 while cnt < (period >> 1), and 0 otherwise.
//   - This gives a ~50% duty square wave at the requested rate.
//   - sq_out is 0 whenever the channel is disabled or period == 1.
// - Undefined: the port and its logic are absent; tick behaviour is unchanged.
//
// STRUCTURE
// - Package rate_sched_pkg:
//   - sched_state_e enum {IDLE, DIVIDE, COMMIT}.
//   - CNT_W_DEF = 32.
//   - Function clamp_period(q): returns 1 if q == 0 and speed != 0, else q.
// - Sub-module serial_divider #(CNT_W):
//   - Inputs: start, dividend, divisor.
//   - Outputs: done (1-cycle pulse), quotient.
//   - Fixed latency CNT_W cycles from start to done; start is ignored while it is running.
// - The top level holds the FSM, the period/cnt register arrays and the tick/sq_out registers.
//
// TESTING (bench uses BASE_SPEED=1000, NUM_CH=4, CNT_W=32)
// 1. Reset, then program ch0 speed 100 -> busy for 33 cycles; tick[0] every 10 cycles;
//    ch_active = 4'b0001.
// 2. Program ch1 speed 3 -> period 333. Program ch2 speed 2000 -> period 1, tick[2] stuck high.
//    ch0 tick spacing stays exactly 10 throughout both programmings.
// 3. ch0 running; write speed 0 -> COMMIT 1 cycle after accept; tick[0] stays 0;
//    ch_active[0] = 0.
// 4. Hold cfg_valid high continuously -> cfg_ready deasserts during DIVIDE; each request is
//    accepted exactly once; back-to-back accept spacing is 34 cycles.
// 5. Assert reset at cycle 10 of a DIVIDE -> period unchanged at 0 and ch_active = 0;
//    cfg_ready = 1 on the next cycle.
// 6. RATE_SCHED_SQUARE_OUT_EN defined, speed 100 -> sq_out[0] high 5 cycles, low 5 cycles,
//    repeating.

Source files
------------

// File: rtl/rate_sched_pkg.sv
// Shared types and helpers for the rate tick scheduler.
// Used by rate_tick_scheduler and serial_divider.
package rate_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    COMMIT
  } sched_state_e;

  localparam int CNT_W_DEF = 32;

  // A rate above the clock frequency still ticks every cycle.
  function automatic logic [CNT_W_DEF-1:0] clamp_period(
    input logic [CNT_W_DEF-1:0] q,
    input logic                 speed_nz
  );
    return (q == '0 && speed_nz) ? CNT_W_DEF'(1) : q;
  endfunction

endpackage

// File: rtl/rate_tick_scheduler_div.sv
// Restoring divider, one quotient bit per cycle, fixed CNT_W-step run.
// done is high during the final step; quotient holds until the next start.
module serial_divider
  import rate_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             inClock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [CNT_W-1:0] quotient
);

  localparam int SW = $clog2(CNT_W);

  logic             run;
  logic [SW-1:0]    step;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dvs;
  logic [CNT_W:0]   sh;
  logic [CNT_W:0]   diff;

  always_comb begin
    sh   = {rem, quotient[CNT_W-1]};
    diff = sh - {1'b0, dvs};
    done = run && (step == SW'(CNT_W - 1));
  end

  always_ff @(posedge inClock) begin
    if (reset) begin
      run      <= 1'b0;
      step     <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else if (run) begin
      quotient <= {quotient[CNT_W-2:0], ~diff[CNT_W]};
      rem      <= diff[CNT_W] ? sh[CNT_W-1:0] : diff[CNT_W-1:0];
      step     <= step + SW'(1);
      if (done) run <= 1'b0;
    end else if (start) begin
      run      <= 1'b1;
      step     <= '0;
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
    end
  end

endmodule

// File: rtl/rate_tick_scheduler.sv
// Multi-channel rate scheduler: Hz requests become periodic one-cycle ticks.
// Optional sq_out square-wave outputs under RATE_SCHED_SQUARE_OUT_EN.
module rate_tick_scheduler
  import rate_sched_pkg::*;
#(
  parameter int BASE_SPEED = 25000000,
  parameter int NUM_CH     = 4,
  parameter int SPEED_W    = 20,
  parameter int CNT_W      = 32,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               inClock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [SPEED_W-1:0] cfg_speed,
  output logic               busy,
  output logic [NUM_CH-1:0]  ch_active,
  output logic [NUM_CH-1:0]  tick
`ifdef RATE_SCHED_SQUARE_OUT_EN
  ,
  output logic [NUM_CH-1:0]  sq_out
`endif
);

  sched_state_e     state;
  logic [CH_W-1:0]  cap_ch;
  logic             cap_zero;
  logic             accept;
  logic             in_range;
  logic             div_start;
  logic             div_done;
  logic [CNT_W-1:0] quot;
  logic [CNT_W-1:0] new_period;
  logic [CNT_W-1:0] period [NUM_CH];
  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [2**CH_W-1:0] ch_ok;

  for (genvar g = 0; g < 2**CH_W; g++) begin : g_ok
    assign ch_ok[g] = (g < NUM_CH);
  end

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign in_range  = ch_ok[cfg_ch];
  assign div_start = accept && in_range && (cfg_speed != '0);

  assign new_period = cap_zero ? '0 :
    CNT_W'(clamp_period(CNT_W_DEF'(quot), 1'b1));

  serial_divider #(.CNT_W(CNT_W)) u_div (
    .inClock  (inClock),
    .reset    (reset),
    .start    (div_start),
    .dividend (CNT_W'(BASE_SPEED)),
    .divisor  (CNT_W'(cfg_speed)),
    .done     (div_done),
    .quotient (quot)
  );

  always_ff @(posedge inClock) begin
    if (reset) begin
      state    <= IDLE;
      cap_ch   <= '0;
      cap_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && in_range) begin
            cap_ch   <= cfg_ch;
            cap_zero <= (cfg_speed == '0);
            state    <= (cfg_speed == '0) ? COMMIT : DIVIDE;
          end
        end
        DIVIDE: if (div_done) state <= COMMIT;
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit restarts the counter with no tick at the commit edge.
  always_ff @(posedge inClock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        period[i] <= '0;
        cnt[i]    <= '0;
        tick[i]   <= 1'b0;
      end else if (state == COMMIT && cap_ch == CH_W'(i)) begin
        period[i] <= new_period;
        cnt[i]    <= '0;
        tick[i]   <= 1'b0;
      end else if (period[i] != '0) begin
        tick[i] <= (cnt[i] == period[i] - CNT_W'(1));
        cnt[i]  <= (cnt[i] == period[i] - CNT_W'(1)) ?
                   '0 : cnt[i] + CNT_W'(1);
      end else begin
        tick[i] <= 1'b0;
        cnt[i]  <= '0;
      end
    end
  end

  always_comb begin
    ch_active = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_active[i] = (period[i] != '0);
  end

`ifdef RATE_SCHED_SQUARE_OUT_EN
  always_comb begin
    sq_out = '0;
    for (int i = 0; i < NUM_CH; i++)
      sq_out[i] = (cnt[i] < (period[i] >> 1));
  end
`else
  // Tick-only build: no square-wave outputs.
`endif

endmodule

// File: tb/tb_rate_tick_scheduler.sv
// Directed bench for rate_tick_scheduler (BASE_SPEED=1000, NUM_CH=4).
// Square-wave checks are built when RATE_SCHED_SQUARE_OUT_EN is defined.
module tb_rate_tick_scheduler;

  logic        inClock = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [19:0] cfg_speed;
  logic        busy;
  logic [3:0]  ch_active;
  logic [3:0]  tick;
`ifdef RATE_SCHED_SQUARE_OUT_EN
  logic [3:0]  sq_out;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  int last_t0 = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [19:0] speed;
    int          busy_n;
    int          period;
    logic [3:0]  active;
  } vec_t;

  vec_t tbl [6];

  rate_tick_scheduler #(
    .BASE_SPEED (1000),
    .NUM_CH     (4),
    .SPEED_W    (20),
    .CNT_W      (32)
  ) dut (
    .inClock   (inClock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_speed (cfg_speed),
    .busy      (busy),
    .ch_active (ch_active),
    .tick      (tick)
`ifdef RATE_SCHED_SQUARE_OUT_EN
    ,
    .sq_out    (sq_out)
`endif
  );

  always #5 inClock = ~inClock;

  always @(posedge inClock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ch0 spacing must stay 10 while other channels are reprogrammed.
  always @(negedge inClock) begin
    if (mon_en && tick[0]) begin
      if (last_t0 != 0) chk("ch0_spacing", cyc - last_t0, 10);
      last_t0 = cyc;
    end
  end

  // Called at a negedge; returns at the negedge of the first idle cycle.
  task automatic program_ch(input logic [1:0] ch, input logic [19:0] sp,
                            output int busy_n);
    int w;
    w = 0;
    while (!cfg_ready && w < 200) begin
      @(negedge inClock);
      w++;
    end
    chk("ready_before_req", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_speed = sp;
    @(negedge inClock);
    cfg_valid = 1'b0;
    busy_n = 0;
    while (busy && busy_n < 100) begin
      busy_n++;
      @(negedge inClock);
    end
  endtask

  // Called in the cycle right after the commit edge.
  task automatic measure(input int ch, input int p);
    int n;
    chk("commit_no_tick", int'(tick[ch]), 0);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        @(negedge inClock);
        n++;
      end while (!tick[ch] && n <= p + 50);
      chk(r == 0 ? "first_tick" : "tick_spacing", n, p);
    end
  endtask

  initial begin
    int bn;
    int acc [3];
    int seen;
    int w;
    logic [1:0]  rq_ch [3];
    logic [19:0] rq_sp [3];

    tbl[0] = '{2'd0, 20'd100,  33, 10,  4'b0001};
    tbl[1] = '{2'd1, 20'd3,    33, 333, 4'b0011};
    tbl[2] = '{2'd2, 20'd2000, 33, 1,   4'b0111};
    tbl[3] = '{2'd3, 20'd1000, 33, 1,   4'b1111};
    tbl[4] = '{2'd3, 20'd7,    33, 142, 4'b1111};
    tbl[5] = '{2'd0, 20'd0,    1,  0,   4'b1110};

    rq_ch[0] = 2'd1; rq_sp[0] = 20'd50;
    rq_ch[1] = 2'd2; rq_sp[1] = 20'd250;
    rq_ch[2] = 2'd1; rq_sp[2] = 20'd125;

    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_speed = '0;
    repeat (3) @(negedge inClock);
    chk("rst_tick", int'(tick), 0);
    chk("rst_active", int'(ch_active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    reset = 1'b0;
    @(negedge inClock);

`ifdef RATE_SCHED_SQUARE_OUT_EN
    program_ch(2'd0, 20'd100, bn);
    chk("sq_busy", bn, 33);
    for (int k = 0; k < 30; k++) begin
      chk("sq_out0", int'(sq_out[0]), ((k % 10) < 5) ? 1 : 0);
      chk("sq_out1", int'(sq_out[1]), 0);
      @(negedge inClock);
    end
    reset = 1'b1;
    @(negedge inClock);
    reset = 1'b0;
    @(negedge inClock);
`endif

    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        last_t0 = 0;
        mon_en = 1'b1;
      end
      if (k == 5) mon_en = 1'b0;
      program_ch(tbl[k].ch, tbl[k].speed, bn);
      chk("busy_cycles", bn, tbl[k].busy_n);
      chk("ch_active", int'(ch_active), int'(tbl[k].active));
      if (tbl[k].period != 0) begin
        measure(int'(tbl[k].ch), tbl[k].period);
      end else begin
        seen = 0;
        for (int c = 0; c < 30; c++) begin
          if (tick[tbl[k].ch]) seen++;
          @(negedge inClock);
        end
        chk("disabled_ticks", seen, 0);
      end
    end

    // Continuous cfg_valid: one accept per IDLE visit, 34 cycles apart.
    cfg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cfg_ch = rq_ch[k];
      cfg_speed = rq_sp[k];
      w = 0;
      while (!cfg_ready && w < 100) begin
        @(negedge inClock);
        w++;
      end
      chk("hold_ready", int'(cfg_ready), 1);
      acc[k] = cyc;
      @(negedge inClock);
      chk("ready_low_divide", int'(cfg_ready), 0);
    end
    cfg_valid = 1'b0;
    chk("accept_gap0", acc[1] - acc[0], 34);
    chk("accept_gap1", acc[2] - acc[1], 34);
    w = 0;
    while (busy && w < 100) begin
      @(negedge inClock);
      w++;
    end
    chk("hold_idle", int'(busy), 0);
    measure(1, 8);
    chk("hold_active", int'(ch_active), 4'b1110);

    // Reset in the middle of a divide commits nothing.
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_speed = 20'd100;
    @(negedge inClock);
    cfg_valid = 1'b0;
    repeat (9) @(negedge inClock);
    chk("mid_divide_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge inClock);
    reset = 1'b0;
    chk("abort_ready", int'(cfg_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_active", int'(ch_active), 0);
    chk("abort_tick", int'(tick), 0);
    repeat (40) @(negedge inClock);
    chk("abort_later_active", int'(ch_active), 0);
    chk("abort_later_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
